// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronised input, mid-bit sampling, held-valid/read handshake.
// Define UART_RX_GLITCH_FILTER_EN to insert a 3-sample majority filter after the synchroniser.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxvalid,
    input  logic       rxread,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t state;
    state_t state_next;

    logic             rx_meta;
    logic             rx_line;
    logic [CNT_W-1:0] baud_cnt;
    logic             baud_done;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic load_half;
    logic load_full;
    logic sample_bit;
    logic byte_done;
    logic stop_bad;

`ifdef UART_RX_GLITCH_FILTER_EN
    // rx_hist[0] is the second synchroniser stage; the two older samples vote with it.
    logic [2:0] rx_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_hist <= 3'b111;
        end else begin
            rx_meta <= rx;
            rx_hist <= {rx_hist[1:0], rx_meta};
        end
    end

    assign rx_line = (rx_hist[0] & rx_hist[1]) |
                     (rx_hist[0] & rx_hist[2]) |
                     (rx_hist[1] & rx_hist[2]);
`else
    logic rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign rx_line = rx_s;
`endif

    assign baud_done = (baud_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!rx_line) state_next = START;
            START:   if (baud_done) state_next = rx_line ? IDLE : DATA;
            DATA:    if (baud_done && (bit_idx == 3'd7)) state_next = STOP;
            // Leaving at mid-stop leaves half a bit to catch an immediately following start edge.
            STOP:    if (baud_done) state_next = rx_line ? IDLE : BREAK;
            BREAK:   if (rx_line) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        load_half  = 1'b0;
        load_full  = 1'b0;
        sample_bit = 1'b0;
        byte_done  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE:  load_half = !rx_line;
            START: load_full = baud_done && !rx_line;
            DATA: begin
                sample_bit = baud_done;
                load_full  = baud_done;
            end
            STOP: begin
                byte_done = baud_done && rx_line;
                stop_bad  = baud_done && !rx_line;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'h00;
        end else begin
            if (load_half) begin
                baud_cnt <= HALF_LOAD;
            end else if (load_full) begin
                baud_cnt <= FULL_LOAD;
            end else if (!baud_done) begin
                baud_cnt <= baud_cnt - CNT_W'(1);
            end

            if (load_half) begin
                bit_idx <= 3'd0;
            end else if (sample_bit) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (sample_bit) begin
                shift[bit_idx] <= rx_line;
            end
        end
    end

    // A read in the completion cycle frees the holding register, so the new byte is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxbyte    <= 8'h00;
            rxvalid   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (byte_done) begin
                if (!rxvalid || rxread) begin
                    rxbyte  <= shift;
                    rxvalid <= 1'b1;
                    overrun <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rxread && rxvalid) begin
                rxvalid <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed testbench for uart_rx_8n1 at 16 clocks per bit.
// Covers reset, clean frames, back-to-back, false start, framing error/break, overrun and glitches.
module tb_uart_rx_8n1;

    localparam int CPB = 16;
`ifdef UART_RX_GLITCH_FILTER_EN
    localparam int LAT = 156;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] rxbyte;
    logic       rxvalid;
    logic       rxread;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fe_count = 0;
    int ov_cycles = 0;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rxbyte    (rxbyte),
        .rxvalid   (rxvalid),
        .rxread    (rxread),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_err) fe_count++;
        if (overrun) ov_cycles++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) clk_step();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) clk_step();
        end
        rx = stop;
        repeat (CPB) clk_step();
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (rxvalid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic read_byte();
        clk_step();
        rxread = 1'b1;
        clk_step();
        rxread = 1'b0;
    endtask

    task automatic test_reset();
        rx = 1'b1;
        rxread = 1'b0;
        rst_n = 1'b0;
        repeat (3) clk_step();
        total++; if (rxbyte !== 8'h00) begin bad++; $display("FAIL reset_rxbyte got=%h want=00", rxbyte); end
        total++; if (rxvalid !== 1'b0) begin bad++; $display("FAIL reset_rxvalid got=%b want=0", rxvalid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst_n = 1'b1;
        repeat (4) clk_step();
    endtask

    task automatic test_clean_frame();
        int fe0;
        int t0;
        int lat;
        bit ok;
        fe0 = fe_count;
        t0 = cyc;
        lat = 0;
        ok = 1'b0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                wait_valid(400, ok);
                lat = cyc - t0;
                total++; if (!ok) begin bad++; $display("FAIL clean_valid got=timeout want=rxvalid"); end
                total++; if (lat < LAT - 1 || lat > LAT + 1) begin bad++; $display("FAIL clean_latency got=%0d want=%0d+-1", lat, LAT); end
                total++; if (rxbyte !== 8'h55) begin bad++; $display("FAIL clean_byte got=%h want=55", rxbyte); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL clean_busy_after_stop got=%b want=0", busy); end
            end
        join
        total++; if (fe_count != fe0) begin bad++; $display("FAIL clean_frame_err got=%0d want=0 pulses", fe_count - fe0); end
        read_byte();
        total++; if (rxvalid !== 1'b0) begin bad++; $display("FAIL clean_read_clears got=%b want=0", rxvalid); end
    endtask

    task automatic test_back_to_back();
        int ov0;
        ov0 = ov_cycles;
        fork
            for (int i = 0; i < 10; i++) send_frame(8'h30 + 8'(i), 1'b1);
            for (int j = 0; j < 10; j++) begin
                bit ok;
                wait_valid(400, ok);
                total++;
                if (!ok || rxbyte !== 8'h30 + 8'(j)) begin
                    bad++;
                    $display("FAIL b2b_byte%0d got=%h valid=%b want=%h", j, rxbyte, ok, 8'h30 + 8'(j));
                end
                read_byte();
            end
        join
        total++; if (ov_cycles != ov0) begin bad++; $display("FAIL b2b_overrun got=%0d cycles want=0", ov_cycles - ov0); end
    endtask

    task automatic test_false_start();
        int fe0;
        int ov0;
        int busy_cnt;
        int val_cnt;
        bit ok;
        fe0 = fe_count;
        ov0 = ov_cycles;
        busy_cnt = 0;
        val_cnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 45; i++) begin
            if (i == 5) rx = 1'b1;
            @(negedge clk);
            if (busy) busy_cnt++;
            if (rxvalid) val_cnt++;
            clk_step();
        end
        total++; if (busy_cnt == 0 || busy_cnt >= CPB) begin bad++; $display("FAIL false_busy_pulse got=%0d cycles want=1..%0d", busy_cnt, CPB - 1); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL false_idle got=%b want=0", busy); end
        total++; if (val_cnt != 0) begin bad++; $display("FAIL false_rxvalid got=%0d cycles want=0", val_cnt); end
        total++; if (fe_count != fe0 || ov_cycles != ov0) begin bad++; $display("FAIL false_status got=fe%0d ov%0d want=0 0", fe_count - fe0, ov_cycles - ov0); end
        fork
            send_frame(8'h7E, 1'b1);
            wait_valid(400, ok);
        join
        total++; if (!ok || rxbyte !== 8'h7E) begin bad++; $display("FAIL false_next_byte got=%h valid=%b want=7e", rxbyte, ok); end
        read_byte();
    endtask

    task automatic test_frame_error();
        int fe0;
        int val_cnt;
        fe0 = fe_count;
        val_cnt = 0;
        send_frame(8'hA5, 1'b0);
        for (int i = 0; i < 40 * CPB; i++) begin
            @(negedge clk);
            if (rxvalid) val_cnt++;
            clk_step();
        end
        total++; if (fe_count - fe0 != 1) begin bad++; $display("FAIL ferr_pulses got=%0d want=1", fe_count - fe0); end
        total++; if (val_cnt != 0 || rxvalid !== 1'b0) begin bad++; $display("FAIL ferr_rxvalid got=%0d cycles want=0", val_cnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_in_break got=%b want=1", busy); end
        rx = 1'b1;
        repeat (6) clk_step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_after_release got=%b want=0", busy); end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        total++; if (rxbyte !== 8'h11) begin bad++; $display("FAIL ovr_byte got=%h want=11", rxbyte); end
        total++; if (overrun !== 1'b1 || rxvalid !== 1'b1) begin bad++; $display("FAIL ovr_flags got=ov%b v%b want=ov1 v1", overrun, rxvalid); end
        read_byte();
        total++; if (rxvalid !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=ov%b v%b want=ov0 v0", overrun, rxvalid); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h5A, 1'b1);
        send_frame(8'h6B, 1'b1);
        rx = 1'b0;
        repeat (CPB) clk_step();
        rx = 1'b1;
        repeat (40) clk_step();
        total++; if (busy !== 1'b1 || overrun !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=busy%b ov%b want=busy1 ov1", busy, overrun); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (rxbyte !== 8'h00 || rxvalid !== 1'b0) begin bad++; $display("FAIL rstmid_data got=%h v%b want=00 v0", rxbyte, rxvalid); end
        total++; if (busy !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_status got=busy%b ov%b fe%b want=0 0 0", busy, overrun, frame_err); end
        repeat (3) clk_step();
        rst_n = 1'b1;
        repeat (3) clk_step();
        send_frame(8'hC3, 1'b1);
        total++; if (rxvalid !== 1'b1 || rxbyte !== 8'hC3) begin bad++; $display("FAIL rstmid_next got=%h v%b want=c3 v1", rxbyte, rxvalid); end
        read_byte();
    endtask

    task automatic test_glitch();
        logic [7:0] want;
`ifdef UART_RX_GLITCH_FILTER_EN
        want = 8'h00;
`else
        want = 8'h08;
`endif
        rx = 1'b0;
        repeat (CPB) clk_step();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < CPB; k++) begin
                rx = (i == 3 && k == 8) ? 1'b1 : 1'b0;
                clk_step();
            end
        end
        rx = 1'b1;
        repeat (CPB) clk_step();
        total++; if (rxvalid !== 1'b1 || rxbyte !== want) begin bad++; $display("FAIL glitch_byte got=%h v%b want=%h", rxbyte, rxvalid, want); end
        read_byte();
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_back_to_back();
        test_false_start();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        test_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
